clear_score_ctrl: RTL

Sequences the post-lock line-clear flow of the Tetris core.
- Accepts a "piece locked, N lines completed" event from the board logic.
- Drives the hit flash for a line-count-dependent duration.
- Commands the board to collapse rows and waits for completion.
- Accumulates score as base points × (level+1) by repeated addition, then updates the line total and level.
- Sits between the board/lock logic and the score/display path; the board logic never updates score directly.

---
 rtl/clear_score_pkg.sv | 39 +++
 rtl/clear_score_ctrl_flash_timer.sv | 41 ++++
 rtl/clear_score_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/clear_score_pkg.sv
// Shared types and lookup helpers for the line-clear / scoring controller.
// The flash lengths are passed in as arguments so that the package stays free of module parameters.
package clear_score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        CLEAR = 2'd2,
        SCORE = 2'd3
    } state_t;

    localparam int FLASH_W = 8;

    function automatic logic [3:0] base_points(input logic [2:0] n);
        logic [3:0] pts;
        case (n)
            3'd0:    pts = 4'd0;
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
        return pts;
    endfunction

    function automatic logic [FLASH_W-1:0] flash_len(input logic [2:0] n,
                                                     input int f1, input int f2,
                                                     input int f3, input int f4);
        logic [FLASH_W-1:0] len;
        case (n)
            3'd1:    len = FLASH_W'(f1);
            3'd2:    len = FLASH_W'(f2);
            3'd3:    len = FLASH_W'(f3);
            default: len = FLASH_W'(f4);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/clear_score_ctrl_flash_timer.sv
// Loadable down-counter driving a registered enable for exactly load_val cycles.
// last marks the final active cycle so the owner can step on without an extra bubble.
module flash_timer
    import clear_score_pkg::*;
#(
    parameter int W = FLASH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         hit,
    output logic         last
);

    logic [W-1:0] cnt_reg;
    logic         hit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            hit_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            hit_reg <= 1'b0;
        end else if (load) begin
            cnt_reg <= load_val;
            hit_reg <= (load_val != '0);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
            hit_reg <= (cnt_reg > W'(1));
        end else begin
            hit_reg <= 1'b0;
        end
    end

    assign hit  = hit_reg;
    assign last = (cnt_reg == W'(1));

endmodule

// File: rtl/clear_score_ctrl.sv
// Post-lock sequencer: flash, board collapse handshake, then score by repeated addition
// of the per-line base value, once per (level+1) latched at acceptance.
module clear_score_ctrl
    import clear_score_pkg::*;
#(
    parameter int FLASH_1    = 3,
    parameter int FLASH_2    = 8,
    parameter int FLASH_3    = 15,
    parameter int FLASH_4    = 24,
    parameter int SCORE_W    = 16,
    parameter int LEVEL_STEP = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_clr,
    input  logic               lock_valid,
    input  logic [2:0]         lock_lines,
    output logic               lock_ready,
    output logic               hit_flash,
    output logic               board_clear_go,
    input  logic               board_clear_done,
    output logic               busy,
    output logic [SCORE_W-1:0] score,
    output logic [9:0]         lines_total,
    output logic [3:0]         level
);

    state_t             state_reg, state_next;
    logic [2:0]         n_reg;
    logic [4:0]         mult_reg;
    logic               clear_first_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [9:0]         lines_reg;
    logic [3:0]         level_reg;
    logic [7:0]         lvl_cnt_reg;

    logic [2:0]         n_eff;
    logic               accept;
    logic               done_seen;
    logic               timer_hit;
    logic               timer_last;
    logic [10:0]        lines_sum;
    logic [7:0]         lvl_sum;
    logic [SCORE_W:0]   score_sum;

    assign n_eff     = (lock_lines > 3'd4) ? 3'd4 : lock_lines;
    assign accept    = lock_valid && (state_reg == IDLE) && !game_clr && (n_eff != 3'd0);
    // The go cycle itself never counts as completion, even if done is already high.
    assign done_seen = (state_reg == CLEAR) && !clear_first_reg && board_clear_done;

    assign lines_sum = {1'b0, lines_reg} + {8'b0, n_reg};
    assign lvl_sum   = lvl_cnt_reg + {5'b0, n_reg};
    assign score_sum = {1'b0, score_reg} + (SCORE_W+1)'(base_points(n_reg));

    flash_timer #(.W(FLASH_W)) u_flash (
        .clk      (clk),
        .rst      (rst),
        .clr      (game_clr),
        .load     (accept),
        .load_val (flash_len(n_eff, FLASH_1, FLASH_2, FLASH_3, FLASH_4)),
        .hit      (timer_hit),
        .last     (timer_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)          state_next = FLASH;
            FLASH:   if (timer_last)      state_next = CLEAR;
            CLEAR:   if (done_seen)       state_next = SCORE;
            SCORE:   if (mult_reg <= 5'd1) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
        if (game_clr) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            n_reg           <= '0;
            mult_reg        <= '0;
            clear_first_reg <= 1'b0;
            score_reg       <= '0;
            lines_reg       <= '0;
            level_reg       <= '0;
            lvl_cnt_reg     <= '0;
        end else if (game_clr) begin
            state_reg       <= IDLE;
            n_reg           <= '0;
            mult_reg        <= '0;
            clear_first_reg <= 1'b0;
            score_reg       <= '0;
            lines_reg       <= '0;
            level_reg       <= '0;
            lvl_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            clear_first_reg <= (state_reg == FLASH) && (state_next == CLEAR);
            if (accept) begin
                n_reg    <= n_eff;
                mult_reg <= {1'b0, level_reg} + 5'd1;
            end
            if (done_seen) begin
                lines_reg <= lines_sum[10] ? 10'd1023 : lines_sum[9:0];
                if (lvl_sum >= 8'(LEVEL_STEP)) begin
                    lvl_cnt_reg <= lvl_sum - 8'(LEVEL_STEP);
                    if (level_reg != 4'd15) begin
                        level_reg <= level_reg + 4'd1;
                    end
                end else begin
                    lvl_cnt_reg <= lvl_sum;
                end
            end
            if (state_reg == SCORE) begin
                score_reg <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                mult_reg  <= mult_reg - 5'd1;
            end
        end
    end

    assign lock_ready     = (state_reg == IDLE);
    assign busy           = (state_reg != IDLE);
    assign board_clear_go = (state_reg == CLEAR) && clear_first_reg;
    assign hit_flash      = timer_hit;
    assign score          = score_reg;
    assign lines_total    = lines_reg;
    assign level          = level_reg;

endmodule
